// File: rtl/mips_mem_pkg.sv
// Shared encodings for the unified memory port arbiter.
package mips_mem_pkg;

    localparam int AW_DEF     = 10;
    localparam int DW_DEF     = 32;
    localparam int STARVE_DEF = 4;

    typedef enum logic [1:0] {
        MODE_LOAD = 2'b00,
        MODE_RUN  = 2'b01,
        MODE_HALT = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_IF   = 2'd1,
        REQ_LS   = 2'd2,
        REQ_DBG  = 2'd3
    } req_id_e;

endpackage

// File: rtl/arb_prio3.sv
// Combinational 3-way priority picker. Bit 0 = IF, bit 1 = LS, bit 2 = DBG.
// Normal order LS > IF > DBG; if_boost_i lifts IF above LS.
module arb_prio3 (
    input  logic [2:0] req_i,
    input  logic [2:0] elig_i,
    input  logic       if_boost_i,
    output logic [2:0] gnt_o
);

    logic [2:0] cand;

    assign cand = req_i & elig_i;

    // One-hot pick among eligible requesters
    always_comb begin
        gnt_o = '0;
        if (if_boost_i && cand[0]) begin
            gnt_o = 3'b001;
        end else if (cand[1]) begin
            gnt_o = 3'b010;
        end else if (cand[0]) begin
            gnt_o = 3'b001;
        end else if (cand[2]) begin
            gnt_o = 3'b100;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for IF / LS / DBG with LOAD/RUN/HALT run mode.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_MAX = STARVE_DEF
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          start,
    input  logic          halt_in,
    output logic [1:0]    mode,
    input  logic          if_req,
    input  logic          ls_req,
    input  logic          dbg_req,
    input  logic          ls_we,
    input  logic          dbg_we,
    input  logic [AW-1:0] if_addr,
    input  logic [AW-1:0] ls_addr,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] ls_wdata,
    input  logic [DW-1:0] dbg_wdata,
    output logic          if_gnt,
    output logic          ls_gnt,
    output logic          dbg_gnt,
    output logic          if_rvalid,
    output logic          ls_rvalid,
    output logic          dbg_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    mode_e   mode_q, mode_d;
    logic [SW-1:0] starve_q, starve_d;
    req_id_e owner_q, owner_d;

    logic [2:0] elig;
    logic [2:0] gnt;
    logic       if_boost;

    // Run-mode next state; halt_in beats start while running
    always_comb begin
        mode_d = mode_q;
        unique case (mode_q)
            MODE_LOAD: if (start)   mode_d = MODE_RUN;
            MODE_RUN:  if (halt_in) mode_d = MODE_HALT;
            MODE_HALT: if (start)   mode_d = MODE_RUN;
            default:                mode_d = MODE_LOAD;
        endcase
    end

    // Eligibility per mode; reset forces every grant low immediately
    always_comb begin
        elig = '0;
        unique case (mode_q)
            MODE_LOAD: elig = 3'b100;
            MODE_RUN:  elig = 3'b111;
            MODE_HALT: elig = 3'b110;
            default:   elig = '0;
        endcase
        if (rst) begin
            elig = '0;
        end
    end

    assign if_boost = (mode_q == MODE_RUN) && (starve_q >= SW'(STARVE_MAX));

    arb_prio3 u_arb (
        .req_i      ({dbg_req, ls_req, if_req}),
        .elig_i     (elig),
        .if_boost_i (if_boost),
        .gnt_o      (gnt)
    );

    assign if_gnt  = gnt[0];
    assign ls_gnt  = gnt[1];
    assign dbg_gnt = gnt[2];

    // Memory strobe mux and owner of the next-cycle read response
    always_comb begin
        mem_en    = |gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        owner_d   = REQ_NONE;
        if (gnt[0]) begin
            mem_addr = if_addr;
            owner_d  = REQ_IF;
        end else if (gnt[1]) begin
            mem_we    = ls_we;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
            owner_d   = ls_we ? REQ_NONE : REQ_LS;
        end else if (gnt[2]) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            owner_d   = dbg_we ? REQ_NONE : REQ_DBG;
        end
    end

    // IF starvation count: only meaningful while staying in RUN
    always_comb begin
        starve_d = starve_q;
        if (mode_q != MODE_RUN || mode_d != MODE_RUN || gnt[0]) begin
            starve_d = '0;
        end else if (if_req && starve_q < SW'(STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // State registers
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            mode_q   <= MODE_LOAD;
            starve_q <= '0;
            owner_q  <= REQ_NONE;
        end else begin
            mode_q   <= mode_d;
            starve_q <= starve_d;
            owner_q  <= owner_d;
        end
    end

    assign mode       = mode_q;
    assign if_rvalid  = (owner_q == REQ_IF);
    assign ls_rvalid  = (owner_q == REQ_LS);
    assign dbg_rvalid = (owner_q == REQ_DBG);
    assign rdata      = mem_rdata;

endmodule
